// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, synchronous flush and bubble fill.
// Optional perf counters (stall_cnt, bubble_cnt) when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_hs #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_chk
    $error("pipe_stage_hs: WIDTH and CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             acc, dlv;

  // in_ready depends only on registered state (and rst), so a downstream stall
  // never ripples combinationally upstream.
  assign in_ready  = (state_q != S_TWO) & ~rst;
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;
  assign acc       = in_valid & in_ready;
  assign dlv       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (acc) begin
          state_d = S_ONE;
          main_d  = in_data;
        end
      end
      S_ONE: begin
        if (acc && !dlv) begin
          state_d = S_TWO;
          skid_d  = in_data;
        end else if (acc && dlv) begin
          main_d = in_data;
        end else if (dlv) begin
          state_d = S_EMPTY;
          main_d  = BUBBLE;
        end
      end
      S_TWO: begin
        if (dlv) begin
          state_d = S_ONE;
          main_d  = skid_q;
          skid_d  = BUBBLE;
        end
      end
      default: begin
        state_d = S_EMPTY;
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
      end
    endcase
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Both counters saturate at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (!out_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
